mux_scan_serializer: RTL and testbench

//   Upstream driver and downstream consumer for the combinational N:1 bit-select mux.

---
 rtl/mux_scan_pkg.sv | 16 +
 rtl/mux_scan_sel_cnt.sv | 44 ++++
 rtl/mux_scan_serializer.sv | 84 ++++++++
 tb/tb_mux_scan_serializer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and limits for the mux scan serializer and its select counter.
package mux_scan_pkg;

   localparam int MAX_INPUTS = 16;
   localparam int MIN_INPUTS = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   function automatic int sel_w(int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/mux_scan_sel_cnt.sv
// Modulo-INPUTS select counter: loads the first channel, steps toward the last, flags the last.
// Latency: select updates one cycle after load/step; is_last is combinational from the register.
module mux_scan_sel_cnt
   import mux_scan_pkg::*;
#(
   parameter  int INPUTS    = 6,
   parameter  bit MSB_FIRST = 1'b0,
   localparam int SEL_W     = sel_w(INPUTS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   output logic [SEL_W-1:0] sel_o,
   output logic             is_last_o
);

   localparam logic [SEL_W-1:0] TOP   = SEL_W'(INPUTS - 1);
   localparam logic [SEL_W-1:0] FIRST = MSB_FIRST ? TOP : SEL_W'(0);
   localparam logic [SEL_W-1:0] LAST  = MSB_FIRST ? SEL_W'(0) : TOP;

   logic [SEL_W-1:0] sel_q, sel_d;

   // Wrapping on LAST keeps the select inside 0..INPUTS-1 even for non power-of-2 sizes.
   always_comb begin
      sel_d = sel_q;
      if (load_i) begin
         sel_d = FIRST;
      end else if (step_i) begin
         if (sel_q == LAST)  sel_d = FIRST;
         else if (MSB_FIRST) sel_d = sel_q - 1'b1;
         else                sel_d = sel_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sel_q <= '0;
      else        sel_q <= sel_d;
   end

   assign sel_o     = sel_q;
   assign is_last_o = (sel_q == LAST);

endmodule

// File: rtl/mux_scan_serializer.sv
// Holds a parallel word on the mux data bus, scans the select and streams the mux output bit.
// First bit one cycle after accept; back-to-back words without a bubble; stalls hold everything.
module mux_scan_serializer
   import mux_scan_pkg::*;
#(
   parameter  int INPUTS    = 6,
   parameter  bit MSB_FIRST = 1'b0,
   localparam int SEL_W     = sel_w(INPUTS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INPUTS-1:0] in_data,
   output logic [INPUTS-1:0] mux_a,
   output logic [SEL_W-1:0]  mux_s,
   input  logic              mux_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_bit,
   output logic              out_last,
   output logic              err
);

   if (INPUTS < MIN_INPUTS || INPUTS > MAX_INPUTS) begin : g_bad_inputs
      $error("mux_scan_serializer: INPUTS=%0d outside %0d..%0d", INPUTS, MIN_INPUTS, MAX_INPUTS);
   end

   state_t            state_q, state_d;
   logic [INPUTS-1:0] mux_a_q, mux_a_d;
   logic              err_q, err_d;
   logic              scan, is_last, accept, beat, step_sel;

   assign scan      = (state_q == SCAN);
   assign out_valid = scan;
   assign out_bit   = mux_y;
   assign out_last  = scan & is_last;
   // Ready passes straight through from out_ready on the final beat so words stream gap-free.
   assign in_ready  = ~scan | (out_last & out_ready);
   assign accept    = in_valid & in_ready;
   assign beat      = out_valid & out_ready;
   assign step_sel  = beat & ~is_last;
   assign mux_a     = mux_a_q;
   assign err       = err_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SCAN;
         SCAN:    if (beat && is_last) state_d = accept ? SCAN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mux_a_d = accept ? in_data : mux_a_q;
      err_d   = err_q | (beat & (mux_y != mux_a_q[mux_s]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mux_a_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mux_a_q <= mux_a_d;
         err_q   <= err_d;
      end
   end

   mux_scan_sel_cnt #(
      .INPUTS    (INPUTS),
      .MSB_FIRST (MSB_FIRST)
   ) u_sel_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (accept),
      .step_i    (step_sel),
      .sel_o     (mux_s),
      .is_last_o (is_last)
   );

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for two serializer instances (6 channels LSB-first, 16 channels MSB-first) against a word/position model.
module tb_mux_scan_serializer;

   logic        clk;
   logic        rst_n;
   logic        in_valid  [2];
   logic        out_ready [2];
   logic        inj       [2];
   logic [15:0] in_data   [2];
   logic        in_ready  [2];
   logic        out_valid [2];
   logic        out_bit   [2];
   logic        out_last  [2];
   logic        err       [2];

   logic [5:0]  mux_a0;
   logic [2:0]  mux_s0;
   logic        mux_y0;
   logic [15:0] mux_a1;
   logic [3:0]  mux_s1;
   logic        mux_y1;
   logic [15:0] obs_a [2];
   logic [3:0]  obs_s [2];

   // Behavioural N:1 mux with an optional inverted output for fault injection.
   assign mux_y0   = mux_a0[mux_s0] ^ inj[0];
   assign mux_y1   = mux_a1[mux_s1] ^ inj[1];
   assign obs_a[0] = {10'd0, mux_a0};
   assign obs_a[1] = mux_a1;
   assign obs_s[0] = {1'b0, mux_s0};
   assign obs_s[1] = mux_s1;

   mux_scan_serializer #(.INPUTS(6), .MSB_FIRST(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0][5:0]),
      .mux_a(mux_a0), .mux_s(mux_s0), .mux_y(mux_y0),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_bit(out_bit[0]),
      .out_last(out_last[0]), .err(err[0])
   );

   mux_scan_serializer #(.INPUTS(16), .MSB_FIRST(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .mux_a(mux_a1), .mux_s(mux_s1), .mux_y(mux_y1),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_bit(out_bit[1]),
      .out_last(out_last[1]), .err(err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: each instance holds one word and the count of bits already delivered.
   int          n_ch  [2];
   bit          msb   [2];
   logic [15:0] m_word[2];
   int          m_pos [2];
   bit          m_act [2];
   bit          m_err [2];
   bit          m_acc [2];
   int          n_checks;
   int          n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic string tg(input string s, input int i);
      return $sformatf("%s[%0d]", s, i);
   endfunction

   function automatic int exp_sel(input int i);
      return msb[i] ? (n_ch[i] - 1 - m_pos[i]) : m_pos[i];
   endfunction

   // One clock: check outputs at the falling edge, advance the model at the rising edge.
   task automatic cycle();
      bit rdy_exp [2];
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         bit last;
         int sel;
         sel        = exp_sel(i);
         last       = m_act[i] && (m_pos[i] == n_ch[i] - 1);
         rdy_exp[i] = !m_act[i] || (last && out_ready[i]);
         check(tg("out_valid", i), 32'(out_valid[i]), 32'(m_act[i]));
         check(tg("in_ready", i),  32'(in_ready[i]),  32'(rdy_exp[i]));
         check(tg("out_last", i),  32'(out_last[i]),  32'(last));
         check(tg("err", i),       32'(err[i]),       32'(m_err[i]));
         if (m_act[i]) begin
            check(tg("mux_s", i),   32'(obs_s[i]),   32'(sel));
            check(tg("out_bit", i), 32'(out_bit[i]), 32'(m_word[i][sel] ^ inj[i]));
            check(tg("mux_a", i),   32'(obs_a[i]),   32'(m_word[i]));
         end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         m_acc[i] = 1'b0;
         if (m_act[i] && out_ready[i]) begin
            if (inj[i]) m_err[i] = 1'b1;
            m_pos[i]++;
            if (m_pos[i] == n_ch[i]) m_act[i] = 1'b0;
         end
         if (in_valid[i] && rdy_exp[i]) begin
            m_word[i] = in_data[i] & 16'((32'd1 << n_ch[i]) - 1);
            m_pos[i]  = 0;
            m_act[i]  = 1'b1;
            m_acc[i]  = 1'b1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0;
         inj[i]      = 1'b0;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         check(tg("rst_out_valid", i), 32'(out_valid[i]), 32'd0);
         check(tg("rst_in_ready", i),  32'(in_ready[i]),  32'd1);
         check(tg("rst_out_last", i),  32'(out_last[i]),  32'd0);
         check(tg("rst_mux_s", i),     32'(obs_s[i]),     32'd0);
         check(tg("rst_mux_a", i),     32'(obs_a[i]),     32'd0);
         check(tg("rst_err", i),       32'(err[i]),       32'd0);
         m_act[i] = 1'b0;
         m_pos[i] = 0;
         m_err[i] = 1'b0;
         m_acc[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send(input int i, input logic [15:0] data);
      int k;
      in_valid[i] = 1'b1;
      in_data[i]  = data;
      k = 0;
      do begin
         cycle();
         k++;
      end while (!m_acc[i] && k < 40);
      if (!m_acc[i]) check(tg("accept_timeout", i), 32'd0, 32'd1);
      in_valid[i] = 1'b0;
   endtask

   task automatic run_to_pos(input int i, input int pos);
      int k;
      k = 0;
      while ((!m_act[i] || m_pos[i] != pos) && k < 40) begin
         cycle();
         k++;
      end
      if (k >= 40) check(tg("pos_timeout", i), 32'(m_pos[i]), 32'(pos));
   endtask

   task automatic run_idle(input int i);
      int k;
      k = 0;
      while (m_act[i] && k < 60) begin
         cycle();
         k++;
      end
      if (m_act[i]) check(tg("idle_timeout", i), 32'd1, 32'd0);
      cycle();
   endtask

   initial begin
      int hold;
      n_checks = 0;
      n_fail   = 0;
      n_ch     = '{6, 16};
      msb      = '{1'b0, 1'b1};
      rst_n    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
         inj[i]       = 1'b0;
         in_data[i]   = '0;
         m_word[i]    = '0;
      end
      #2;
      do_reset();

      // Single word, free-running downstream.
      send(0, 16'b101101);
      run_idle(0);

      // Stall three cycles on channel 2.
      send(0, 16'b101101);
      hold = 0;
      for (int k = 0; k < 30 && m_act[0]; k++) begin
         out_ready[0] = !(m_pos[0] == 2 && hold < 3);
         if (!out_ready[0]) hold++;
         cycle();
      end
      out_ready[0] = 1'b1;
      check("stall_cycles", 32'(hold), 32'd3);
      run_idle(0);

      // Back-to-back words with valid held.
      in_valid[0] = 1'b1;
      in_data[0]  = 16'h2A;
      cycle();
      in_data[0]  = 16'h15;
      for (int k = 0; k < 20 && !m_acc[0]; k++) cycle();
      check("b2b_second_accept", 32'(m_acc[0]), 32'd1);
      in_valid[0] = 1'b0;
      run_idle(0);

      // Reset mid-scan, then a clean restart.
      send(0, 16'h3F);
      run_to_pos(0, 3);
      do_reset();
      send(0, 16'h21);
      run_idle(0);

      // Inverted mux output on channel 4 makes err sticky until reset.
      send(0, 16'h0F);
      run_to_pos(0, 4);
      inj[0] = 1'b1;
      cycle();
      inj[0] = 1'b0;
      run_idle(0);
      send(0, 16'h33);
      run_idle(0);
      check("err_sticky", 32'(err[0]), 32'd1);
      do_reset();

      // Sixteen channels, MSB first.
      send(1, 16'h8001);
      run_idle(1);

      // Random traffic on both instances with occasional faults and resets.
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!in_valid[i] || m_acc[i]) begin
               in_valid[i] = ($urandom_range(0, 3) != 0);
               in_data[i]  = 16'($urandom);
            end
            out_ready[i] = ($urandom_range(0, 3) != 0);
            inj[i]       = ($urandom_range(0, 299) == 0);
         end
         cycle();
         if (c % 800 == 799) do_reset();
      end
      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
         inj[i]       = 1'b0;
      end
      run_idle(0);
      run_idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
